ascii_line_receiver: RTL

//  Receive-side counterpart of the UART ASCII sender path. Consumes bytes from the UART RX
//  (one rx_done pulse per byte) and assembles them into a line buffer with backspace editing.
//  On CR/LF it reports the line length and whether the line equals the keyword "hello".

---
 rtl/ascii_line_receiver_pkg.sv | 36 +++
 rtl/ascii_line_receiver_pattern_cmp.sv | 19 +
 rtl/ascii_line_receiver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ascii_line_receiver_pkg.sv
// Shared constants, state encodings and byte classification for the ASCII line receiver.
package ascii_line_receiver_pkg;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    // Keyword pattern; the first character sits in the most significant byte.
    localparam int                   PAT_LEN   = 5;
    localparam logic [PAT_LEN*8-1:0] PAT_HELLO = "hello";

    // Receiver states, kept as plain constants for compatibility with older tooling.
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    typedef enum logic [1:0] {
        CLS_DATA  = 2'd0,
        CLS_TERM  = 2'd1,
        CLS_ERASE = 2'd2
    } byte_class_e;

    // Sort a received byte into terminator, erase or ordinary data.
    function automatic byte_class_e classify_byte(input logic [7:0] b);
        byte_class_e cls;
        if (b == ASCII_CR || b == ASCII_LF) begin
            cls = CLS_TERM;
        end else if (b == ASCII_BS || b == ASCII_DEL) begin
            cls = CLS_ERASE;
        end else begin
            cls = CLS_DATA;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ascii_line_receiver_pattern_cmp.sv
// Combinational keyword comparator: matches when the line length equals the
// pattern length and the leading buffer bytes equal the pattern.
module ascii_pattern_cmp
    import ascii_line_receiver_pkg::*;
#(
    parameter int                       PAT_LEN_P = PAT_LEN,
    parameter int                       CNT_W     = 5,
    parameter logic [PAT_LEN_P*8-1:0]   PATTERN   = PAT_HELLO
) (
    input  logic [PAT_LEN_P*8-1:0] slice,
    input  logic [CNT_W-1:0]       count,
    output logic                   match
);

    localparam logic [CNT_W-1:0] PAT_CNT = CNT_W'(PAT_LEN_P);

    assign match = (count == PAT_CNT) && (slice == PATTERN);

endmodule

// File: rtl/ascii_line_receiver.sv
// Line assembler behind a UART RX: buffers bytes with backspace editing, reports
// length / keyword match / overflow one cycle after a CR or LF terminator.
module ascii_line_receiver
    import ascii_line_receiver_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              line_done,
    output logic [ADDR_W:0]   line_len,
    output logic              line_match,
    output logic              line_overflow,
    output logic              busy
);

    localparam int              MAX_LEN = 2**ADDR_W;
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_LEN);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    // Register array (not block RAM) so that reset can clear every entry.
    logic [7:0]           line_buf [MAX_LEN];
    logic [ADDR_W:0]      count;
    logic [0:0]           state;

    byte_class_e          byte_cls_p0;
    logic                 wr_en_p0;
    logic                 hello_hit_p0;
    logic [PAT_LEN*8-1:0] pat_slice_p0;

    // ---- stage p0: decode the incoming byte against the registered buffer ----
    assign byte_cls_p0 = classify_byte(rx_data);
    assign wr_en_p0    = rx_done && (state == ST_COLLECT) &&
                         (byte_cls_p0 == CLS_DATA) && (count < MAX_CNT);

    assign rd_data = line_buf[rd_addr];
    assign busy    = (count != '0) || (state == ST_DISCARD);

    // Gather the leading buffer entries, first character in the top byte.
    always_comb begin
        pat_slice_p0 = '0;
        for (int i = 0; i < PAT_LEN; i++) begin
            pat_slice_p0[(PAT_LEN-1-i)*8 +: 8] = line_buf[i];
        end
    end

    ascii_pattern_cmp #(
        .PAT_LEN_P (PAT_LEN),
        .CNT_W     (ADDR_W+1),
        .PATTERN   (PAT_HELLO)
    ) u_hello_cmp (
        .slice (pat_slice_p0),
        .count (count),
        .match (hello_hit_p0)
    );

    // Store DATA bytes at the write position; reset wipes the whole buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                line_buf[i] <= 8'h00;
            end
        end else if (wr_en_p0) begin
            line_buf[count[ADDR_W-1:0]] <= rx_data;
        end
    end

    // ---- stage p1: line state machine and held line report ----
    // Track fill level / discard mode and publish the result on a terminator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_COLLECT;
            count         <= '0;
            line_done     <= 1'b0;
            line_len      <= '0;
            line_match    <= 1'b0;
            line_overflow <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (rx_done) begin
                case (state)
                    ST_COLLECT: begin
                        unique case (byte_cls_p0)
                            CLS_DATA: begin
                                if (count < MAX_CNT) begin
                                    count <= count + CNT_ONE;
                                end else begin
                                    state <= ST_DISCARD;
                                end
                            end
                            CLS_ERASE: begin
                                if (count != '0) begin
                                    count <= count - CNT_ONE;
                                end
                            end
                            CLS_TERM: begin
                                // Empty lines (including the LF of CR+LF) stay silent.
                                if (count != '0) begin
                                    line_done     <= 1'b1;
                                    line_len      <= count;
                                    line_overflow <= 1'b0;
                                    line_match    <= hello_hit_p0;
                                    count         <= '0;
                                end
                            end
                            default: begin
                                count <= count;
                            end
                        endcase
                    end
                    ST_DISCARD: begin
                        if (byte_cls_p0 == CLS_TERM) begin
                            line_done     <= 1'b1;
                            line_len      <= MAX_CNT;
                            line_overflow <= 1'b1;
                            line_match    <= 1'b0;
                            count         <= '0;
                            state         <= ST_COLLECT;
                        end
                    end
                    default: begin
                        state <= ST_COLLECT;
                    end
                endcase
            end
        end
    end

endmodule
